// File: rtl/np_ingress.sv
// ---------------------------------------------------------------------------
// np_ingress -- packet ingress loader for the np core input memory.
//
// Accepts 32-bit packet words from a valid/ready stream and writes them into
// the input memory starting at address 1. When the last word arrives it
// writes a length header to address 0 (optionally preceded by a payload
// checksum written just past the payload). It then releases the core with
// np_run and holds the stream off until the core reports np_halt. Only one
// packet is resident at a time.
//
// Optional feature: define NP_INGRESS_CSUM_EN to enable the modulo-2^32
// payload checksum that is stored at address len+1.
//
// Ports:
//   clk          rising-edge system clock
//   reset        asynchronous active-low reset
//   s_valid      stream word valid
//   s_data       stream word
//   s_last       final word of the packet (qualified by s_valid)
//   s_ready      loader can accept a word
//   mem_address  input-memory write address (registered)
//   mem_dataOut  input-memory write data (registered)
//   mem_wr       input-memory write enable (registered)
//   np_run       core enable, low holds the core idle (registered)
//   np_halt      core finished the current packet
//   pkt_count    packets completed, wraps at 2^16 (registered)
// ---------------------------------------------------------------------------
module np_ingress #(
   parameter int WIDTH    = 32,
   parameter int ADDRSIZE = 12
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                s_valid,
   input  logic [WIDTH-1:0]    s_data,
   input  logic                s_last,
   output logic                s_ready,
   output logic [ADDRSIZE-1:0] mem_address,
   output logic [WIDTH-1:0]    mem_dataOut,
   output logic                mem_wr,
   output logic                np_run,
   input  logic                np_halt,
   output logic [15:0]         pkt_count
);

   localparam int                  MEMSIZE = 1 << ADDRSIZE;
   localparam logic [ADDRSIZE-1:0] MAXW    = ADDRSIZE'(MEMSIZE - 2);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_CSUM = 3'd2,
      ST_HDR  = 3'd3,
      ST_RUN  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ADDRSIZE-1:0] len_q, len_d;
   logic                trunc_q, trunc_d;
   logic                ready_q, ready_d;
   logic                run_q, run_d;
   logic                wr_q, wr_d;
   logic [ADDRSIZE-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]    data_q, data_d;
   logic [15:0]         count_q, count_d;
`ifdef NP_INGRESS_CSUM_EN
   logic [WIDTH-1:0]    sum_q, sum_d;
`endif

   logic   accept_s;
   state_t after_last_s;

   // Header word: truncated flag in the MSB, stored payload length in the low bits.
   function automatic logic [WIDTH-1:0] make_header(input logic                trunc,
                                                    input logic [ADDRSIZE-1:0] len);
      logic [WIDTH-1:0] h;
      h                 = '0;
      h[WIDTH-1]        = trunc;
      h[ADDRSIZE-1:0]   = len;
      return h;
   endfunction

   // s_ready is a decode of the registered state, forced low while reset is
   // held so the stream sees "not ready" during reset and "ready" the moment
   // reset is released (the state register already holds IDLE).
   assign s_ready     = ready_q & reset;
   assign accept_s    = s_valid & ready_q;
   assign mem_address = addr_q;
   assign mem_dataOut = data_q;
   assign mem_wr      = wr_q;
   assign np_run      = run_q;
   assign pkt_count   = count_q;

`ifdef NP_INGRESS_CSUM_EN
   assign after_last_s = ST_CSUM;
`else
   assign after_last_s = ST_HDR;
`endif

   // Next-state and registered-output computation for the loader FSM.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      trunc_d = trunc_q;
      run_d   = run_q;
      wr_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      count_d = count_q;
`ifdef NP_INGRESS_CSUM_EN
      sum_d   = sum_q;
`endif

      case (state_q)
         ST_IDLE: begin
            run_d = 1'b0;
            if (accept_s) begin
               wr_d   = 1'b1;
               addr_d = ADDRSIZE'(1);
               data_d = s_data;
               len_d  = ADDRSIZE'(1);
`ifdef NP_INGRESS_CSUM_EN
               sum_d  = s_data;
`endif
               if (s_last) begin
                  state_d = after_last_s;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_LOAD: begin
            if (accept_s) begin
               // Once the payload area is full, further beats are drained
               // without a write so the sender never stalls.
               if (len_q < MAXW) begin
                  wr_d   = 1'b1;
                  addr_d = len_q + 1'b1;
                  data_d = s_data;
                  len_d  = len_q + 1'b1;
`ifdef NP_INGRESS_CSUM_EN
                  sum_d  = sum_q + s_data;
`endif
               end else begin
                  trunc_d = 1'b1;
               end
               if (s_last) begin
                  state_d = after_last_s;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end

         ST_CSUM: begin
`ifdef NP_INGRESS_CSUM_EN
            wr_d   = 1'b1;
            addr_d = len_q + 1'b1;
            data_d = sum_q;
`endif
            state_d = ST_HDR;
         end

         ST_HDR: begin
            wr_d    = 1'b1;
            addr_d  = '0;
            data_d  = make_header(trunc_q, len_q);
            state_d = ST_RUN;
         end

         ST_RUN: begin
            // np_run rises one cycle after entering RUN so that the header
            // write is captured before the core starts; halt is only honoured
            // once the core has actually been released, which ignores a halt
            // level left over from the previous packet.
            if (run_q && np_halt) begin
               state_d = ST_IDLE;
               run_d   = 1'b0;
               count_d = count_q + 16'd1;
               len_d   = '0;
               trunc_d = 1'b0;
`ifdef NP_INGRESS_CSUM_EN
               sum_d   = '0;
`endif
            end else begin
               run_d   = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            run_d   = 1'b0;
         end
      endcase

      ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         trunc_q <= 1'b0;
         ready_q <= 1'b1;
         run_q   <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         count_q <= 16'd0;
`ifdef NP_INGRESS_CSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         trunc_q <= trunc_d;
         ready_q <= ready_d;
         run_q   <= run_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         count_q <= count_d;
`ifdef NP_INGRESS_CSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

endmodule

// File: tb/tb_np_ingress.sv
// ---------------------------------------------------------------------------
// tb_np_ingress -- self-checking bench for np_ingress.
// Expected memory writes are pushed to a scoreboard queue as beats are driven
// and popped by a monitor that samples the write port on the falling edge.
// ---------------------------------------------------------------------------
module tb_np_ingress;

   localparam int MAXW = 4094;
`ifdef NP_INGRESS_CSUM_EN
   localparam int EXP_LAT = 4;
`else
   localparam int EXP_LAT = 3;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_last;
   logic        s_ready;
   logic [11:0] mem_address;
   logic [31:0] mem_dataOut;
   logic        mem_wr;
   logic        np_run;
   logic        np_halt;
   logic [15:0] pkt_count;

   int checks = 0;
   int errors = 0;
   int exp_count = 0;
   logic [43:0] sb[$];
   logic [43:0] mon_exp;

   np_ingress dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
      .mem_address(mem_address), .mem_dataOut(mem_dataOut), .mem_wr(mem_wr),
      .np_run(np_run), .np_halt(np_halt), .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   // Write monitor: every write must match the next scoreboard entry.
   always @(negedge clk) begin
      if (reset === 1'b1 && mem_wr === 1'b1) begin
         checks++;
         if (np_run !== 1'b0) begin
            errors++;
            $display("FAIL wr_during_run: np_run=%b required 0 at addr %h", np_run, mem_address);
         end
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%h data=%h, no write expected", mem_address, mem_dataOut);
         end else begin
            mon_exp = sb.pop_front();
            if ({mem_address, mem_dataOut} !== mon_exp) begin
               errors++;
               $display("FAIL mem_write: got addr=%h data=%h, required addr=%h data=%h",
                        mem_address, mem_dataOut, mon_exp[43:32], mon_exp[31:0]);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_beat(input logic [31:0] d, input logic l);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      for (int k = 0; k < 50; k++) begin
         if (s_ready === 1'b1) begin
            @(posedge clk);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL beat_accept: data=%h not accepted within 50 cycles, required accept", d);
      end
   endtask

   // Drives an n-beat packet (word i = base*(i+1)) and queues the expected writes.
   task automatic send_pkt(input int n, input logic [31:0] base, input bit gap);
      logic [31:0] d;
      logic [31:0] sum;
      int          stored;
      logic        trunc;
      sum = 32'd0;
      stored = 0;
      trunc = 1'b0;
      for (int i = 0; i < n; i++) begin
         d = base * 32'(i + 1);
         if (gap && i > 0) @(negedge clk);
         if (i < MAXW) begin
            sb.push_back({12'(i + 1), d});
            sum = sum + d;
            stored++;
         end else begin
            trunc = 1'b1;
         end
         send_beat(d, (i == n - 1));
      end
`ifdef NP_INGRESS_CSUM_EN
      sb.push_back({12'(stored + 1), sum});
`endif
      sb.push_back({12'd0, trunc, 19'd0, 12'(stored)});
   endtask

   task automatic finish_pkt(input string name);
      int lat;
      lat = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         lat++;
         checks++;
         if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_low: s_ready=%b required 0 before run", name, s_ready);
         end
         if (np_run === 1'b1) break;
      end
      checks++;
      if (lat !== EXP_LAT || np_run !== 1'b1) begin
         errors++;
         $display("FAIL %s_run_latency: np_run=%b after %0d cycles, required 1 after %0d", name, np_run, lat, EXP_LAT);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_writes_done: %0d writes outstanding, required 0", name, sb.size());
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (s_ready !== 1'b0 || np_run !== 1'b1) begin
            errors++;
            $display("FAIL %s_run_hold: s_ready=%b np_run=%b required 0/1", name, s_ready, np_run);
         end
      end
   endtask

   task automatic do_halt(input string name);
      @(negedge clk);
      np_halt = 1'b1;
      @(posedge clk);
      #1;
      np_halt = 1'b0;
      exp_count++;
      checks++;
      if (np_run !== 1'b0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_halt_release: np_run=%b s_ready=%b required 0/1", name, np_run, s_ready);
      end
      checks++;
      if (pkt_count !== 16'(exp_count)) begin
         errors++;
         $display("FAIL %s_pkt_count: got %0d required %0d", name, pkt_count, exp_count);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      s_valid = 1'b0;
      s_data = 32'd0;
      s_last = 1'b0;
      np_halt = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (s_ready !== 1'b0 || mem_wr !== 1'b0 || np_run !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: s_ready=%b mem_wr=%b np_run=%b required 0/0/0", s_ready, mem_wr, np_run);
      end
      checks++;
      if (mem_address !== 12'd0 || mem_dataOut !== 32'd0 || pkt_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_data: addr=%h data=%h cnt=%0d required 0/0/0", mem_address, mem_dataOut, pkt_count);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: s_ready=%b required 1", s_ready);
      end
   endtask

   task automatic test_basic();
      send_pkt(3, 32'h11, 1'b0);
      finish_pkt("basic");
      do_halt("basic");
   endtask

   task automatic test_back_to_back();
      // Starts right after the halt edge of the previous test.
      send_pkt(3, 32'h7, 1'b0);
      finish_pkt("b2b");
      do_halt("b2b");
   endtask

   task automatic test_truncate();
      send_pkt(4100, 32'h1, 1'b0);
      finish_pkt("trunc");
      do_halt("trunc");
   endtask

   task automatic test_reset_mid();
      sb.push_back({12'd1, 32'h1});
      sb.push_back({12'd2, 32'h2});
      send_beat(32'h1, 1'b0);
      send_beat(32'h2, 1'b0);
      #1;
      reset = 1'b0;
      sb.delete();
      #1;
      checks++;
      if (np_run !== 1'b0 || mem_wr !== 1'b0 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: np_run=%b mem_wr=%b s_ready=%b required 0/0/0", np_run, mem_wr, s_ready);
      end
      @(negedge clk);
      reset = 1'b1;
      exp_count = 0;
      send_pkt(1, 32'hAA, 1'b0);
      finish_pkt("after_reset");
      do_halt("after_reset");
   endtask

   task automatic test_toggle_halt_idle();
      @(negedge clk);
      np_halt = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (s_ready !== 1'b1 || pkt_count !== 16'(exp_count)) begin
            errors++;
            $display("FAIL idle_halt: s_ready=%b cnt=%0d required 1/%0d", s_ready, pkt_count, exp_count);
         end
      end
      send_pkt(3, 32'h5, 1'b1);
      np_halt = 1'b0;
      checks++;
      if (pkt_count !== 16'(exp_count)) begin
         errors++;
         $display("FAIL toggle_count: got %0d required %0d", pkt_count, exp_count);
      end
      finish_pkt("toggle");
      do_halt("toggle");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_truncate();
      test_reset_mid();
      test_toggle_halt_idle();
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL final_scoreboard: %0d writes outstanding, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
